// File: rtl/regfile_port_ctrl.sv
// Port controller for the 32x32 RV32I register file: post-reset clear of x1..x31,
// core pass-through, and a single debug port with bounded starvation against core writeback.
module regfile_port_ctrl #(
  parameter int XLEN         = 32,
  parameter int AW           = 5,
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   core_rs1,
  input  logic [AW-1:0]   core_rs2,
  input  logic [AW-1:0]   core_rd,
  input  logic [XLEN-1:0] core_rd_data,
  input  logic            core_reg_write,
  output logic            core_stall,
  output logic            init_done,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_ack,
  output logic [XLEN-1:0] dbg_rdata,
  output logic [AW-1:0]   rf_rs1,
  output logic [AW-1:0]   rf_rs2,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_rd_data,
  output logic            rf_reg_write,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DBG  = 2'd2;

  localparam logic [3:0]    MAX_WAIT = 4'(DBG_MAX_WAIT);
  localparam logic [AW-1:0] LAST_REG = {AW{1'b1}};

  logic [1:0]      state_reg, state_next;
  logic [AW-1:0]   clr_cnt_reg, clr_cnt_next;
  logic [3:0]      wait_cnt_reg, wait_cnt_next;
  logic            dbg_ack_reg, dbg_ack_next;
  logic [XLEN-1:0] dbg_rdata_reg, dbg_rdata_next;
  logic            init_done_reg, init_done_next;
  logic            dbg_pending;
  logic            grant;

  // Second read port data is reserved; kept only so the port stays connected.
  logic rs2_data_unused;
  assign rs2_data_unused = ^rf_rs2_data;

  assign dbg_ack   = dbg_ack_reg;
  assign dbg_rdata = dbg_rdata_reg;
  assign init_done = init_done_reg;

  // A request seen during its own ack cycle is stale: the requester is about to drop it.
  assign dbg_pending = dbg_req && !dbg_ack_reg;
  assign grant       = dbg_pending && (!core_reg_write || (wait_cnt_reg == MAX_WAIT));

  always_comb begin
    rf_rs1       = core_rs1;
    rf_rs2       = core_rs2;
    rf_rd        = core_rd;
    rf_rd_data   = core_rd_data;
    rf_reg_write = core_reg_write && (core_rd != '0);
    core_stall   = 1'b0;
    case (state_reg)
      ST_INIT: begin
        rf_rd        = clr_cnt_reg;
        rf_rd_data   = '0;
        rf_reg_write = 1'b1;
        core_stall   = 1'b1;
      end
      ST_DBG: begin
        core_stall   = 1'b1;
        rf_rs1       = dbg_addr;
        rf_rd        = dbg_addr;
        rf_rd_data   = dbg_wdata;
        rf_reg_write = dbg_we && (dbg_addr != '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    clr_cnt_next   = clr_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    dbg_ack_next   = 1'b0;
    dbg_rdata_next = dbg_rdata_reg;
    init_done_next = init_done_reg;
    case (state_reg)
      ST_INIT: begin
        clr_cnt_next  = clr_cnt_reg + AW'(1);
        wait_cnt_next = '0;
        if (clr_cnt_reg == LAST_REG) begin
          state_next     = ST_RUN;
          init_done_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (grant) begin
          state_next    = ST_DBG;
          wait_cnt_next = '0;
        end else if (dbg_pending) begin
          if (wait_cnt_reg != MAX_WAIT) wait_cnt_next = wait_cnt_reg + 4'd1;
        end else begin
          wait_cnt_next = '0;
        end
      end
      ST_DBG: begin
        // The register file returns the pre-write value; x0 always reads as zero.
        dbg_rdata_next = (dbg_addr == '0) ? '0 : rf_rs1_data;
        dbg_ack_next   = 1'b1;
        state_next     = ST_RUN;
      end
      default: begin
        state_next   = ST_INIT;
        clr_cnt_next = AW'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_INIT;
      clr_cnt_reg   <= AW'(1);
      wait_cnt_reg  <= '0;
      dbg_ack_reg   <= 1'b0;
      dbg_rdata_reg <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clr_cnt_reg   <= clr_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      dbg_ack_reg   <= dbg_ack_next;
      dbg_rdata_reg <= dbg_rdata_next;
      init_done_reg <= init_done_next;
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: models the register file behind the rf_* ports and checks
// clear sequence, pass-through, debug arbitration and reset-abort against a register-level model.
module tb_regfile_port_ctrl;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  core_rs1 = '0, core_rs2 = '0, core_rd = '0;
  logic [31:0] core_rd_data = '0;
  logic        core_reg_write = 1'b0;
  logic        core_stall, init_done;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic [31:0] rf_rd_data, rf_rs1_data, rf_rs2_data;
  logic        rf_reg_write;

  regfile_port_ctrl #(.XLEN(32), .AW(5), .DBG_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .core_rs1(core_rs1), .core_rs2(core_rs2), .core_rd(core_rd),
    .core_rd_data(core_rd_data), .core_reg_write(core_reg_write),
    .core_stall(core_stall), .init_done(init_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data),
    .rf_reg_write(rf_reg_write), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data)
  );

  always #5 clk = ~clk;

  // Register file behind the controller; preload fills it with junk so the clear is visible.
  logic [31:0] rf_mem [32];
  logic        preload = 1'b0;
  int          x0_writes = 0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 1; i < 32; i++) rf_mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (rf_reg_write) begin
      rf_mem[rf_rd] <= rf_rd_data;
      if (rf_rd == 5'd0) x0_writes <= x0_writes + 1;
    end
  end
  assign rf_rs1_data = (rf_rs1 == 5'd0) ? 32'd0 : rf_mem[rf_rs1];
  assign rf_rs2_data = (rf_rs2 == 5'd0) ? 32'd0 : rf_mem[rf_rs2];

  int errors = 0;
  int checks = 0;
  logic [31:0] ref_rf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] data;
    logic        we;
    logic        exp_wr;
  } vec_t;
  vec_t vecs [6];

  // Random-phase model state
  logic        m_in_dbg, m_ack, prev_dbg, exp_wr;
  int          m_wait, lat, edges, dbg_edge;
  logic [31:0] m_rdata, n_rdata;
  int          nonzero;

  initial begin
    vecs[0] = '{rs1: 5'd1,  rs2: 5'd2,  rd: 5'd5,  data: 32'hDEAD_BEEF, we: 1'b1, exp_wr: 1'b1};
    vecs[1] = '{rs1: 5'd5,  rs2: 5'd3,  rd: 5'd0,  data: 32'h0000_1234, we: 1'b1, exp_wr: 1'b0};
    vecs[2] = '{rs1: 5'd31, rs2: 5'd30, rd: 5'd31, data: 32'hCAFE_F00D, we: 1'b0, exp_wr: 1'b0};
    vecs[3] = '{rs1: 5'd4,  rs2: 5'd6,  rd: 5'd12, data: 32'h0000_1111, we: 1'b1, exp_wr: 1'b1};
    vecs[4] = '{rs1: 5'd0,  rs2: 5'd31, rd: 5'd31, data: 32'h8000_0001, we: 1'b1, exp_wr: 1'b1};
    vecs[5] = '{rs1: 5'd2,  rs2: 5'd9,  rd: 5'd1,  data: 32'hFFFF_FFFF, we: 1'b0, exp_wr: 1'b0};
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;

    // Reset for three edges, then the 31-write clear sequence.
    rst = 1'b1;
    preload = 1'b1;
    repeat (3) step();
    preload = 1'b0;
    chk("reset_ack", dbg_ack, 1'b0);
    chk("reset_rdata", dbg_rdata, 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk("init_we", rf_reg_write, 1'b1);
      chk("init_rd", rf_rd, i);
      chk("init_data", rf_rd_data, 32'd0);
      chk("init_stall", core_stall, 1'b1);
      chk("init_done_early", init_done, 1'b0);
      step();
    end
    @(negedge clk);
    chk("init_done", init_done, 1'b1);
    chk("run_stall", core_stall, 1'b0);
    nonzero = 0;
    for (int i = 1; i < 32; i++) if (rf_mem[i] !== 32'd0) nonzero++;
    chk("init_clear_count", nonzero, 0);
    chk("init_x0_writes", x0_writes, 0);
    step();

    // Table-driven core pass-through.
    for (int v = 0; v < 6; v++) begin
      core_rs1 = vecs[v].rs1; core_rs2 = vecs[v].rs2; core_rd = vecs[v].rd;
      core_rd_data = vecs[v].data; core_reg_write = vecs[v].we;
      @(negedge clk);
      chk("vec_rs1", rf_rs1, vecs[v].rs1);
      chk("vec_rs2", rf_rs2, vecs[v].rs2);
      chk("vec_rd", rf_rd, vecs[v].rd);
      chk("vec_data", rf_rd_data, vecs[v].data);
      chk("vec_we", rf_reg_write, vecs[v].exp_wr);
      chk("vec_stall", core_stall, 1'b0);
      $display("vec %0d: rd=%0d data=%h we=%0b rf_we=%0b", v, vecs[v].rd, vecs[v].data, vecs[v].we, rf_reg_write);
      if (vecs[v].we && vecs[v].rd != 5'd0) ref_rf[vecs[v].rd] = vecs[v].data;
      step();
    end
    core_reg_write = 1'b0;

    // Debug read of x5 with an idle core: ack two edges after the request.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
    @(negedge clk);
    chk("rd5_req_stall", core_stall, 1'b0);
    step();
    @(negedge clk);
    chk("rd5_dbg_stall", core_stall, 1'b1);
    chk("rd5_dbg_rs1", rf_rs1, 5'd5);
    chk("rd5_dbg_we", rf_reg_write, 1'b0);
    chk("rd5_dbg_ack_early", dbg_ack, 1'b0);
    step();
    chk("rd5_ack", dbg_ack, 1'b1);
    chk("rd5_rdata", dbg_rdata, 32'hDEAD_BEEF);
    $display("dbg read x5 -> %h", dbg_rdata);
    dbg_req = 1'b0;
    step();
    chk("rd5_ack_pulse", dbg_ack, 1'b0);
    chk("rd5_rdata_hold", dbg_rdata, 32'hDEAD_BEEF);

    // Debug write to x0: no register write, reads back zero.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFFFF_FFFF;
    step();
    @(negedge clk);
    chk("x0_dbg_stall", core_stall, 1'b1);
    chk("x0_dbg_we", rf_reg_write, 1'b0);
    step();
    chk("x0_ack", dbg_ack, 1'b1);
    chk("x0_rdata", dbg_rdata, 32'd0);
    $display("dbg write x0 <- ffffffff, ack=%0b rdata=%h", dbg_ack, dbg_rdata);
    dbg_req = 1'b0;
    step();

    // Debug write x7 under continuous core writeback: deferred until the wait limit.
    core_reg_write = 1'b1; core_rd = 5'd9; core_rd_data = 32'h0000_0099;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h0000_00AA;
    edges = 0; dbg_edge = -1;
    while (edges < 20 && !(edges > 0 && dbg_ack)) begin
      @(negedge clk);
      if (core_stall) begin
        dbg_edge = edges;
        chk("wr7_dbg_rd", rf_rd, 5'd7);
        chk("wr7_dbg_data", rf_rd_data, 32'h0000_00AA);
        chk("wr7_dbg_we", rf_reg_write, 1'b1);
      end
      step();
      edges++;
    end
    chk("wr7_ack_edge", edges, MAXW + 2);
    chk("wr7_dbg_edge", dbg_edge, MAXW + 1);
    chk("wr7_rdata", dbg_rdata, 32'd0);
    dbg_req = 1'b0;
    @(negedge clk);
    chk("wr7_core_reissue_we", rf_reg_write, 1'b1);
    chk("wr7_core_reissue_rd", rf_rd, 5'd9);
    chk("wr7_core_stall", core_stall, 1'b0);
    step();
    chk("wr7_mem", rf_mem[7], 32'h0000_00AA);
    $display("dbg write x7 <- aa, ack after %0d edges", edges);
    ref_rf[7] = 32'h0000_00AA;
    ref_rf[9] = 32'h0000_0099;

    // Randomized traffic against the register-level model.
    m_in_dbg = 1'b0; m_ack = 1'b0; m_wait = 0; prev_dbg = 1'b0; lat = 0; m_rdata = 32'd0;
    for (int c = 0; c < 600; c++) begin
      if (!prev_dbg) begin
        core_reg_write = 1'($urandom_range(0, 1));
        core_rd = 5'($urandom_range(0, 31));
        core_rs1 = 5'($urandom_range(0, 31));
        core_rs2 = 5'($urandom_range(0, 31));
        core_rd_data = $urandom;
      end
      if (dbg_req && dbg_ack) begin
        chk("rand_latency", 32'((lat >= 2) && (lat <= MAXW + 2)), 32'd1);
        $display("dbg txn we=%0b addr=%0d wdata=%h rdata=%h lat=%0d", dbg_we, dbg_addr, dbg_wdata, dbg_rdata, lat);
        dbg_req = 1'b0;
      end else if (dbg_req && lat > MAXW + 4) begin
        checks++; errors++;
        $display("FAIL rand_timeout: got no ack after %0d edges, required at most %0d", lat, MAXW + 2);
        dbg_req = 1'b0;
      end else if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req = 1'b1;
        dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = 5'($urandom_range(0, 31));
        dbg_wdata = $urandom;
        lat = 0;
      end
      @(negedge clk);
      exp_wr = m_in_dbg ? (dbg_we && dbg_addr != 5'd0) : (core_reg_write && core_rd != 5'd0);
      chk("rand_stall", core_stall, m_in_dbg);
      chk("rand_ack", dbg_ack, m_ack);
      chk("rand_rdata", dbg_rdata, m_rdata);
      chk("rand_we", rf_reg_write, exp_wr);
      prev_dbg = m_in_dbg;
      if (m_in_dbg) begin
        n_rdata = (dbg_addr == 5'd0) ? 32'd0 : ref_rf[dbg_addr];
        if (dbg_we && dbg_addr != 5'd0) ref_rf[dbg_addr] = dbg_wdata;
        m_rdata = n_rdata;
        m_ack = 1'b1;
        m_in_dbg = 1'b0;
      end else begin
        if (core_reg_write && core_rd != 5'd0) ref_rf[core_rd] = core_rd_data;
        if (dbg_req && !m_ack) begin
          if (!core_reg_write || m_wait == MAXW) begin
            m_in_dbg = 1'b1;
            m_wait = 0;
          end else begin
            m_wait++;
          end
        end else if (!dbg_req) begin
          m_wait = 0;
        end
        m_ack = 1'b0;
      end
      step();
      if (dbg_req) lat++;
    end
    dbg_req = 1'b0; core_reg_write = 1'b0;
    repeat (3) step();
    for (int i = 1; i < 32; i++) chk("final_reg", rf_mem[i], ref_rf[i]);
    chk("final_x0_writes", x0_writes, 0);

    // Reset arriving during a DBG cycle aborts the access and restarts the clear.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
    step();
    @(negedge clk);
    chk("abort_in_dbg", core_stall, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    dbg_req = 1'b0;
    chk("abort_no_ack", dbg_ack, 1'b0);
    chk("abort_rdata", dbg_rdata, 32'd0);
    chk("abort_init_done", init_done, 1'b0);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk("abort_clear_rd", rf_rd, i);
      chk("abort_clear_we", rf_reg_write, 1'b1);
      chk("abort_no_ack_init", dbg_ack, 1'b0);
      step();
    end
    chk("abort_init_done_final", init_done, 1'b1);
    $display("reset abort: clear restarted, init_done=%0b", init_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
